vec_lane_engine: RTL

Parametrised successor to the fixed four-lane signed vector unit. It streams two operand vectors A and B over a single `din` port with a valid/ready handshake, then runs one of four lane-parallel operations on all lanes in a single cycle. Supported operations are add, subtract, multiply, and accumulate-with-saved-C, each with selectable saturation. The result is presented as a packed vector. The block sits between the operand stream source and downstream consumers of the lane results, with its controller and datapath contained in one module.

---
 rtl/vec_lane_engine.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vec_lane_engine.sv
// vec_lane_engine: streams A/B operand vectors, then computes add/sub/mul/acc on all lanes in one cycle.
module vec_lane_engine #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic                     sat_en,
  input  logic                     clr_c,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [LANES*WIDTH-1:0]   f,
  output logic                     f_valid,
  output logic                     done,
  output logic                     busy
);
  localparam int CW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int XW = 2 * WIDTH + 2;
  localparam logic signed [XW-1:0] HI = {{(WIDTH + 3){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [XW-1:0] LO = {{(WIDTH + 3){1'b1}}, {(WIDTH - 1){1'b0}}};
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, EXEC} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic sat_q, sat_d, f_valid_q, f_valid_d, done_q, done_d, last;
  logic signed [WIDTH-1:0] a_q [LANES], a_d [LANES], b_q [LANES], b_d [LANES];
  logic signed [WIDTH-1:0] c_q [LANES], c_d [LANES], f_q [LANES], f_d [LANES], r [LANES];

  // XW bits hold every full-precision result exactly, so clamping is a plain compare
  function automatic logic signed [WIDTH-1:0] lane(input logic [1:0] o, input logic s,
      input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y, input logic signed [WIDTH-1:0] z);
    logic signed [XW-1:0] xe, ye, ze, w;
    xe = {{(XW - WIDTH){x[WIDTH-1]}}, x};
    ye = {{(XW - WIDTH){y[WIDTH-1]}}, y};
    ze = {{(XW - WIDTH){z[WIDTH-1]}}, z};
    w = o == 2'd0 ? xe + ye : o == 2'd1 ? xe - ye : o == 2'd2 ? xe * ye : xe + ye + ze;
    return s && w > HI ? HI[WIDTH-1:0] : s && w < LO ? LO[WIDTH-1:0] : w[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    sat_d = sat_q;
    f_valid_d = f_valid_q;
    done_d = 1'b0;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    f_d = f_q;
    last = cnt_q == CW'(LANES - 1);
    for (int i = 0; i < LANES; i++) r[i] = lane(op_q, sat_q, a_q[i], b_q[i], c_q[i]);
    case (state_q)
      IDLE: begin
        if (clr_c) for (int i = 0; i < LANES; i++) c_d[i] = '0;
        if (start) begin
          state_d = LOAD_A;
          op_d = op;
          sat_d = sat_en;
          f_valid_d = 1'b0;
          cnt_d = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        if (din_valid) begin
          if (state_q == LOAD_A) a_d[cnt_q] = din;
          else b_d[cnt_q] = din;
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (last) state_d = state_q == LOAD_A ? LOAD_B : EXEC;
        end
      end
      EXEC: begin
        f_d = r;
        if (op_q == 2'b11) c_d = r;
        f_valid_d = 1'b1;
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      sat_q <= 1'b0;
      f_valid_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
        f_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      sat_q <= sat_d;
      f_valid_q <= f_valid_d;
      done_q <= done_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      f_q <= f_d;
    end
  end

  always_comb begin
    f = '0;
    for (int i = 0; i < LANES; i++) f[i*WIDTH +: WIDTH] = f_q[i];
  end

  assign din_ready = state_q == LOAD_A || state_q == LOAD_B;
  assign busy = state_q != IDLE;
  assign f_valid = f_valid_q;
  assign done = done_q;
endmodule
